// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle load/store slave over a word-organised SRAM with RISC-V width/sign rules.
// Optional `DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses return resp_err instead of being force-aligned.
module dmem_responder #(
    parameter logic [31:0] BASE    = 32'h10010000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [2:0]    f3_q;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   off, word, sh, ld, wd, merged;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic          mis, err_c, commit;

    assign off = addr_q - BASE;
    assign idx = off[AW+1:2];
    assign word = mem[idx];
`ifdef DMEM_MISALIGN_TRAP_EN
    assign lane = addr_q[1:0];
    assign mis = (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
    assign lane = f3_q[1:0] == 2'b01 ? {addr_q[1], 1'b0} : f3_q[1:0] == 2'b10 ? 2'b00 : addr_q[1:0];
    assign mis = 1'b0;
`endif
    // Addresses below BASE wrap to huge offsets, so one compare covers both ends.
    assign err_c = off >= 32'(DEPTH * 4) || f3_q[1:0] == 2'b11 || mis;
    assign commit = state == WAIT && cnt == 4'd0;

    assign sh = word >> {lane, 3'b000};
    assign ld = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
                f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : sh;
    assign be = f3_q[1:0] == 2'b00 ? 4'b0001 << lane : f3_q[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
    assign wd = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;

    always_comb begin
        merged = word;
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    end

    assign req_ready = state == IDLE;
    assign resp_valid = state == RESP;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (req_valid ? WAIT : IDLE) :
                   state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
                   (resp_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            f3_q       <= 3'd0;
            wdata_q    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                resp_rdata <= (err_c || we_q) ? 32'd0 : ld;
                resp_err   <= err_c;
            end
        end

    // The array has no reset; an async reset drops the FSM out of WAIT so no write lands.
    always_ff @(posedge clk)
        if (commit && we_q && !err_c) mem[idx] <= merged;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a byte-level memory model.
module tb_dmem_responder;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam int DEPTH = 1024;
    localparam int LATENCY = 2;

    logic        clk = 0, rst = 0;
    logic        req_valid = 0, req_we = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [2:0]  req_funct3 = 0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    int          checks = 0, errors = 0;
    logic [7:0]  mm [logic [31:0]];

    dmem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    function automatic void ref_access(input logic we, input logic [31:0] a, input logic [2:0] f,
                                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
        logic [31:0] off, v;
        int nb;
        off = a - BASE;
        nb = f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
        e = off >= 32'(DEPTH * 4) || f[1:0] == 2'b11;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (off % nb != 0) e = 1;
`else
        off = off - off % nb;
`endif
        rd = 0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mm[off + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mm.exists(off + i) ? mm[off + i] : 8'h00;
            if (nb < 4 && !f[2] && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
            rd = v;
        end
    endfunction

    task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat,
                        output logic [31:0] xrd, output logic xe);
        int n;
        ref_access(we, a, f, wd, xrd, xe);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        req_valid = 1; req_we = we; req_addr = a; req_funct3 = f; req_wdata = wd;
        @(posedge clk); #1 req_valid = 0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1 lat++; end
        rd = resp_rdata; e = resp_err;
        resp_ready = 1;
        @(posedge clk); #1 resp_ready = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", resp_err); end
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_word();
        logic [31:0] rd, xrd; logic e, xe; int lat;
        xact(1, BASE + 4, 3'b010, 32'hDEADBEEF, rd, e, lat, xrd, xe);
        checks++; if (lat != LATENCY) begin errors++; $display("FAIL sw_latency got %0d exp %0d", lat, LATENCY); end
        checks++; if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL sw_resp got %h/%b exp 0/0", rd, e); end
        xact(0, BASE + 4, 3'b010, 0, rd, e, lat, xrd, xe);
        checks++; if (lat != LATENCY) begin errors++; $display("FAIL lw_latency got %0d exp %0d", lat, LATENCY); end
        checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_word got %h/%b exp deadbeef/0", rd, e); end
    endtask

    task automatic test_byte();
        logic [31:0] rd, xrd; logic e, xe; int lat;
        xact(1, BASE + 5, 3'b000, 32'h00000080, rd, e, lat, xrd, xe);
        xact(0, BASE + 4, 3'b010, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== 32'hDEAD80EF) begin errors++; $display("FAIL sb_lw got %h exp dead80ef", rd); end
        xact(0, BASE + 5, 3'b000, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h exp ffffff80", rd); end
        xact(0, BASE + 5, 3'b100, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got %h exp 00000080", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd, xrd; logic e, xe; int lat;
        xact(1, BASE + 6, 3'b001, 32'hABCD1234, rd, e, lat, xrd, xe);
        xact(0, BASE + 6, 3'b001, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lh got %h exp 00001234", rd); end
        xact(0, BASE + 4, 3'b010, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== 32'h123480EF) begin errors++; $display("FAIL sh_lw got %h exp 123480ef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, xrd; logic e, xe; int lat;
        xact(0, BASE + DEPTH * 4, 3'b010, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL err_top got %h/%b exp 0/1", rd, e); end
        xact(0, 32'h1000FFFC, 3'b010, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL err_below got %h/%b exp 0/1", rd, e); end
        xact(0, BASE + 4, 3'b011, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL err_funct3 got %h/%b exp 0/1", rd, e); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, xrd; logic e, xe; int lat;
        xact(0, BASE + 6, 3'b010, 0, rd, e, lat, xrd, xe);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL misalign_lw got %h/%b exp 0/1", rd, e); end
`else
        checks++; if (rd !== 32'h123480EF || e !== 1'b0) begin errors++; $display("FAIL misalign_lw got %h/%b exp 123480ef/0", rd, e); end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, xrd; logic e, xe; int n, lat;
        ref_access(0, BASE + 4, 3'b010, 0, xrd, xe);
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = BASE + 4; req_funct3 = 3'b010;
        @(posedge clk); #1 req_valid = 0;
        n = 0;
        while (!resp_valid && n < 50) begin @(posedge clk); #1 n++; end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", resp_valid); end
        req_valid = 1; req_we = 1; req_wdata = 32'h55555555;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== xrd || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold got v=%b d=%h e=%b rr=%b exp v=1 d=%h e=0 rr=0",
                                   resp_valid, resp_rdata, resp_err, req_ready, xrd);
            end
        end
        req_valid = 0; resp_ready = 1;
        @(posedge clk); #1 resp_ready = 0;
        xact(0, BASE + 4, 3'b010, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== xrd) begin errors++; $display("FAIL bp_ignored_req got %h exp %h", rd, xrd); end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd, xrd; logic e, xe; int lat;
        xact(1, BASE + 8, 3'b010, 32'd0, rd, e, lat, xrd, xe);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = BASE + 8; req_funct3 = 3'b010; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1 req_valid = 0;
        rst = 0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL rst_wait_outputs got rr=%b v=%b d=%h e=%b exp 1/0/0/0",
                               req_ready, resp_valid, resp_rdata, resp_err);
        end
        repeat (2) @(negedge clk);
        rst = 1;
        xact(0, BASE + 8, 3'b010, 0, rd, e, lat, xrd, xe);
        checks++; if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL rst_wait_load got %h/%b exp 0/0", rd, e); end
    endtask

    task automatic test_random();
        logic [31:0] rd, xrd, a; logic e, xe; int lat, r;
        for (int i = 0; i < 16; i++) xact(1, BASE + 4 * i, 3'b010, $urandom, rd, e, lat, xrd, xe);
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            a = r == 0 ? BASE + DEPTH * 4 + $urandom_range(0, 64) :
                r == 1 ? BASE - 1 - $urandom_range(0, 64) : BASE + $urandom_range(0, 63);
            xact(1'($urandom), a, 3'($urandom), $urandom, rd, e, lat, xrd, xe);
            checks++;
            if (rd !== xrd || e !== xe || lat != LATENCY) begin
                errors++; $display("FAIL rand_%0d addr=%h got %h/%b/%0d exp %h/%b/%0d", i, a, rd, e, lat, xrd, xe, LATENCY);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_misalign();
        test_backpressure();
        test_reset_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
